fsync_credit_ctr: RTL

- Destination-domain consumer of the flag-synchronizer count output (oflg).
- Accumulates per-cycle flag counts (credits returned from the source domain) into a saturating credit pool.
- Grants multi-credit takes to a local requester via a valid/ready handshake.
- Provides a low-credit indicator, a low-water mark and a sticky overflow error for debug/status registers.

---
 rtl/fsync_credit_ctr_if.sv | 22 ++
 rtl/fsync_credit_ctr.sv | 100 ++++++++++
 2 files changed

// File: rtl/fsync_credit_ctr_if.sv
// rtl/fsync_credit_ctr_if.sv - take handshake between requester and credit pool
interface fsync_credit_ctr_if #(
    parameter int TAKE_W = 4
);
    logic              take_valid;
    logic [TAKE_W-1:0] take_num;
    logic              take_ready;

    // Requester side: asks for take_num credits and waits for ready.
    modport master (
        output take_valid,
        output take_num,
        input  take_ready
    );

    // Pool side: grants a take when enough credits are registered.
    modport slave (
        input  take_valid,
        input  take_num,
        output take_ready
    );
endinterface

// File: rtl/fsync_credit_ctr.sv
// rtl/fsync_credit_ctr.sv - saturating credit pool fed by flag-synchronizer counts
module fsync_credit_ctr #(
    parameter int ADD_W        = 3,
    parameter int MAX_CREDITS  = 64,
    parameter int INIT_CREDITS = 64,
    parameter int TAKE_W       = 4,
    parameter int LOW_THRESH   = 8,
    localparam int CW          = $clog2(MAX_CREDITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADD_W-1:0]     add_cnt,
    fsync_credit_ctr_if.slave    take_if,
    input  logic                 clr_stats,
    output logic [CW-1:0]        credits,
    output logic                 credit_low,
    output logic [CW-1:0]        low_water,
    output logic                 ovf_err
);

    // Sum width leaves headroom for the add on top of a full pool.
    localparam int SW    = ((CW > ADD_W) ? CW : ADD_W) + 2;
    // Compare width covers a take_num wider than the pool counter.
    localparam int CMP_W = (CW > TAKE_W) ? CW : TAKE_W;

    localparam logic [SW-1:0] MAX_S  = SW'(MAX_CREDITS);
    localparam logic [SW-1:0] LOW_S  = SW'(LOW_THRESH);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_CREDITS);
    localparam logic [CW-1:0] INIT_C = CW'(INIT_CREDITS);
    localparam logic          INIT_LOW = (INIT_CREDITS < LOW_THRESH);

    if (INIT_CREDITS > MAX_CREDITS) begin : g_bad_init
        $error("ERROR: INIT_CREDITS exceeds MAX_CREDITS");
    end

    logic [CW-1:0] credits_q,    credits_d;
    logic          credit_low_q, credit_low_d;
    logic [CW-1:0] low_water_q,  low_water_d;
    logic          ovf_err_q,    ovf_err_d;

    logic          take_ready;
    logic          fire;
    logic [SW-1:0] sum;
    logic          ovf_set;

    // Grant against the registered pool only, so a same-cycle add never funds a take.
    always_comb begin
        take_ready = (CMP_W'(credits_q) >= CMP_W'(take_if.take_num));
        fire       = take_if.take_valid && take_ready;
    end

    assign take_if.take_ready = take_ready;

    // Next pool value, saturation, low flag, low-water mark and sticky overflow.
    always_comb begin
        sum          = SW'(credits_q) + SW'(add_cnt) - (fire ? SW'(take_if.take_num) : '0);
        ovf_set      = 1'b0;
        credits_d    = sum[CW-1:0];
        if (sum > MAX_S) begin
            credits_d = MAX_C;
            ovf_set   = 1'b1;
        end
        credit_low_d = (SW'(credits_d) < LOW_S);
        low_water_d  = low_water_q;
        if (clr_stats || (credits_d < low_water_q)) begin
            low_water_d = credits_d;
        end
        ovf_err_d    = ovf_set || (ovf_err_q && !clr_stats);
    end

    // Pool and status registers; reset restores the initial pool at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q    <= INIT_C;
            credit_low_q <= INIT_LOW;
            low_water_q  <= INIT_C;
            ovf_err_q    <= 1'b0;
        end else begin
            credits_q    <= credits_d;
            credit_low_q <= credit_low_d;
            low_water_q  <= low_water_d;
            ovf_err_q    <= ovf_err_d;
        end
    end

    assign credits    = credits_q;
    assign credit_low = credit_low_q;
    assign low_water  = low_water_q;
    assign ovf_err    = ovf_err_q;

    // Simulation-only protocol checks on the inputs.
    a_no_x_inputs : assert property (@(posedge clk) disable iff (rst)
        !$isunknown({add_cnt, take_if.take_valid}))
        else $error("ERROR: %m X on add_cnt or take_valid");

    a_take_range : assert property (@(posedge clk) disable iff (rst)
        !(take_if.take_valid && (CMP_W'(take_if.take_num) > CMP_W'(MAX_CREDITS))))
        else $error("ERROR: %m take_num exceeds MAX_CREDITS");

endmodule
